// File: rtl/seq_divider_32.sv
// seq_divider_32 -- multi-cycle unsigned restoring divider, one quotient bit per clock.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous reset, active-low
//   start        request a divide; accepted in IDLE or DONE (ignored while busy)
//   dividend     unsigned dividend, captured on an accepted start
//   divisor      unsigned divisor, captured on an accepted start
//   busy         high while iterating (RUN state)
//   done         one-cycle pulse; quotient/remainder/div_by_zero valid in that cycle
//   quotient     result quotient, held until the next completed operation
//   remainder    result remainder, held until the next completed operation
//   div_by_zero  set with done when the divisor was 0, held like the results
//   fsm_state    current FSM state (IDLE=0, RUN=1, DONE=2) for observation
//
// Handshake: start is sampled on a rising edge only when busy==0 (IDLE or DONE
// state); there is no queuing, so a start raised while busy is simply dropped.
// done and busy are never high together. A normal divide shows busy for WIDTH
// cycles after the accepting edge, then done for one cycle; a zero divisor goes
// straight to done in the cycle after the accepting edge.

module seq_divider_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       fsm_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem_acc;
  logic [WIDTH-1:0] quo_acc;
  logic [WIDTH-1:0] divisor_q;

  logic             accept;
  logic             last_step;
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH-1:0] quo_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_step  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = (divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        last_step = (count == CW'(1));
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // A start in the done cycle launches the next operation immediately.
        if (start) begin
          accept     = 1'b1;
          state_next = (divisor == '0) ? DONE : RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign fsm_state = state;

  // ---------------------------------------------------------------------------
  // One restoring iteration: shift {rem,quo} left, trial-subtract the divisor
  // with a borrow bit, keep the difference if no borrow.
  // The top bit of rem_acc shifted out here is always zero: a subtraction
  // keeps rem_acc below the divisor, and before the first subtraction rem_acc
  // holds fewer than WIDTH dividend bits.
  // ---------------------------------------------------------------------------
  always_comb begin
    rem_sh   = {rem_acc[WIDTH-2:0], quo_acc[WIDTH-1]};
    quo_sh   = {quo_acc[WIDTH-2:0], 1'b0};
    diff     = {1'b0, rem_sh} - {1'b0, divisor_q};
    rem_next = rem_sh;
    quo_next = quo_sh;
    if (!diff[WIDTH]) begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo_sh[WIDTH-1:1], 1'b1};
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath. Result registers are written only on the edge entering DONE,
  // so they stay stable through a following RUN.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      rem_acc     <= '0;
      quo_acc     <= '0;
      divisor_q   <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      divisor_q <= divisor;
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        rem_acc <= '0;
        quo_acc <= dividend;
        count   <= CW'(WIDTH);
      end
    end else if (state == RUN) begin
      rem_acc <= rem_next;
      quo_acc <= quo_next;
      count   <= count - CW'(1);
      if (last_step) begin
        quotient    <= quo_next;
        remainder   <= rem_next;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule
